// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop request bus plus the RAM strobe/address/data bundle of the FIFO controller.
// The slave modport is the controller's view; master is the producer/consumer/RAM side.
interface ram_fifo_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
);
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;
   logic             ram_write;
   logic             ram_read;
   logic [AW-1:0]    ram_wr_addr;
   logic [AW-1:0]    ram_rd_addr;
   logic [WIDTH-1:0] ram_data_in;
   logic [WIDTH-1:0] ram_data_out;

   modport slave (
      input  push, push_data, pop, ram_data_out,
      output pop_data, pop_valid, full, empty, count, overflow, underflow,
             ram_write, ram_read, ram_wr_addr, ram_rd_addr, ram_data_in
   );

   modport master (
      output push, push_data, pop, ram_data_out,
      input  pop_data, pop_valid, full, empty, count, overflow, underflow,
             ram_write, ram_read, ram_wr_addr, ram_rd_addr, ram_data_in
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: owns wrap-bit pointers, derives
// full/empty/count from them, and turns push/pop requests into RAM strobes.
module ram_fifo_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic            clk,
   input logic            rst,
   ram_fifo_ctrl_if.slave bus
);
   typedef logic [WIDTH-1:0] data_t;
   typedef logic [AW:0]      ptr_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   logic pop_valid_q, pop_valid_d;
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   logic full, empty, push_ok, pop_ok;

   // The extra MSB distinguishes a full FIFO from an empty one when the low bits match.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign push_ok = bus.push && !full && rst;
   assign pop_ok  = bus.pop && !empty && rst;

   assign bus.ram_write   = push_ok;
   assign bus.ram_read    = pop_ok;
   assign bus.ram_wr_addr = wptr_q[AW-1:0];
   assign bus.ram_rd_addr = rptr_q[AW-1:0];
   assign bus.ram_data_in = rst ? data_t'(bus.push_data) : '0;

   assign bus.pop_data  = bus.ram_data_out;
   assign bus.pop_valid = pop_valid_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = wptr_q - rptr_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      pop_valid_d = pop_ok;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      // A rejected request stays rejected even when the opposite side is accepted.
      if (bus.push && full && rst)  overflow_d  = 1'b1;
      if (bus.pop && empty && rst)  underflow_d = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x8 RAM (registered read port).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ram_fifo_ctrl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ram_fifo_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_q;

   always @(posedge clk) begin
      if (bus.ram_write) mem[bus.ram_wr_addr] <= bus.ram_data_in;
      if (bus.ram_read)  rd_q <= mem[bus.ram_rd_addr];
   end
   assign bus.ram_data_out = rd_q;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic p, input logic [7:0] d, input logic po);
      @(negedge clk);
      rst          = r;
      bus.push     = p;
      bus.push_data = d;
      bus.pop      = po;
      #1;
   endtask

   logic [7:0] q [$];
   logic [7:0] pend;
   logic       pend_v;
   logic       p, po, pok, pook;
   logic [7:0] d;
   int         mw, mr, npush, rv;

   initial begin
      bus.push      = 1'b1;
      bus.push_data = 8'h00;
      bus.pop       = 1'b1;

      // Reset held with both requests asserted
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 8'hEE, 1'b1);
         check("rst_ram_write", bus.ram_write, 0);
         check("rst_ram_read", bus.ram_read, 0);
         check("rst_empty", bus.empty, 1);
         check("rst_count", bus.count, 0);
         check("rst_pop_valid", bus.pop_valid, 0);
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("rel_empty", bus.empty, 1);
      check("rel_full", bus.full, 0);
      check("rel_overflow", bus.overflow, 0);
      check("rel_underflow", bus.underflow, 0);
      check("rel_pop_valid", bus.pop_valid, 0);

      // Fill with 0x10..0x1F
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
         check("fill_write", bus.ram_write, 1);
         check("fill_addr", bus.ram_wr_addr, i);
         check("fill_data", bus.ram_data_in, 8'h10 + i);
         check("fill_count", bus.count, i);
         check("fill_full", bus.full, 0);
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("full_flag", bus.full, 1);
      check("full_count", bus.count, 16);
      check("full_empty", bus.empty, 0);

      // Push while full
      cyc(1'b1, 1'b1, 8'hAA, 1'b0);
      check("ovf_write", bus.ram_write, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("ovf_flag", bus.overflow, 1);
      check("ovf_count", bus.count, 16);

      // Drain; the first pop carries a push that must still be rejected
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, (i == 0), 8'hBB, 1'b1);
         check("drain_read", bus.ram_read, 1);
         check("drain_addr", bus.ram_rd_addr, i);
         check("drain_count", bus.count, 16 - i);
         if (i == 0) check("full_pop_push_rejected", bus.ram_write, 0);
         else begin
            check("drain_valid", bus.pop_valid, 1);
            check("drain_data", bus.pop_data, 8'h10 + i - 1);
         end
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("drain_last_valid", bus.pop_valid, 1);
      check("drain_last_data", bus.pop_data, 8'h1F);
      check("drain_empty", bus.empty, 1);
      check("drain_count0", bus.count, 0);

      // Pop while empty
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      check("unf_read", bus.ram_read, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("unf_flag", bus.underflow, 1);
      check("unf_pop_valid", bus.pop_valid, 0);
      check("unf_ovf_sticky", bus.overflow, 1);

      // Simultaneous push/pop at count 5, wrapping both pointers
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
      for (int j = 0; j < 20; j++) begin
         cyc(1'b1, 1'b1, 8'h55, 1'b1);
         check("sim_count", bus.count, 5);
         check("sim_write", bus.ram_write, 1);
         check("sim_read", bus.ram_read, 1);
         check("sim_wr_addr", bus.ram_wr_addr, (5 + j) % 16);
         check("sim_rd_addr", bus.ram_rd_addr, j % 16);
         check("sim_valid", bus.pop_valid, (j > 0));
         if (j > 0) check("sim_data", bus.pop_data, (j - 1 < 5) ? 8'h60 + j - 1 : 8'h55);
      end

      // Reset, then push and pop together while empty
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b1, 8'h77, 1'b1);
      check("pe_overflow_clr", bus.overflow, 0);
      check("pe_underflow_clr", bus.underflow, 0);
      check("pe_count0", bus.count, 0);
      check("pe_valid_clr", bus.pop_valid, 0);
      check("pe_write", bus.ram_write, 1);
      check("pe_read", bus.ram_read, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("pe_count1", bus.count, 1);
      check("pe_underflow", bus.underflow, 1);
      check("pe_overflow", bus.overflow, 0);
      check("pe_pop_valid", bus.pop_valid, 0);

      // Random interleaved traffic against a queue model
      q = {8'h77};
      mw = 1;
      mr = 0;
      npush = 0;
      pend_v = 1'b0;
      pend = 8'h00;
      for (int k = 0; k < 400 && (npush < 40 || q.size() > 0 || pend_v); k++) begin
         p  = (npush < 40) && (q.size() < 16) && ($urandom_range(0, 1) == 1);
         po = (npush >= 40) || ($urandom_range(0, 1) == 1);
         rv = $random % 256;
         d  = rv[7:0];
         cyc(1'b1, p, d, po);
         pok  = p;
         pook = po && (q.size() > 0);
         check("rnd_count", bus.count, q.size());
         check("rnd_write", bus.ram_write, pok);
         check("rnd_read", bus.ram_read, pook);
         if (pok)  check("rnd_wr_addr", bus.ram_wr_addr, mw);
         if (pook) check("rnd_rd_addr", bus.ram_rd_addr, mr);
         check("rnd_valid", bus.pop_valid, pend_v);
         if (pend_v) check("rnd_data", bus.pop_data, pend);
         pend_v = pook;
         if (pook) begin
            pend = q.pop_front();
            mr = (mr + 1) % 16;
         end
         if (pok) begin
            q.push_back(d);
            mw = (mw + 1) % 16;
            npush++;
         end
      end
      check("rnd_all_pushed", npush, 40);
      check("rnd_drained", q.size(), 0);
      check("rnd_no_overflow", bus.overflow, 0);

      // Reset coinciding with a pop at count 3
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h31 + i), 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check("rstpop_read", bus.ram_read, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      check("rstpop_valid", bus.pop_valid, 0);
      check("rstpop_count", bus.count, 0);
      check("rstpop_empty", bus.empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Initiator-side controller for the 16 x 8 dual-port RAM. It owns the write and read address pointers and turns a push/pop request interface into RAM write/read strobes, so the RAM operates as a synchronous FIFO. It sits between a data producer/consumer pair and one dual-port RAM instance. The RAM itself stays outside this block; `ram_data_out` is returned to the controller.

## Interface
- `WIDTH`, 8, data width; must match the RAM data width.
- `DEPTH`, 16, number of entries; power of two.
- `AW`, 4, address width = log2(DEPTH).
- `clk` input 1, single clock; all logic is rising-edge.
- `rst` input 1, synchronous, active-low reset; sampled on the `clk` rising edge.
- `push` input 1, write request.
- `push_data` input WIDTH, data to store; valid with `push`.
- `pop` input 1, read request.
- `pop_data` output WIDTH, read data; valid only while `pop_valid` = 1.
- `pop_valid` output 1, `pop_data` is valid this cycle.
- `full` output 1, DEPTH entries held.
- `empty` output 1, zero entries held.
- `count` output AW+1, current occupancy, 0..DEPTH.
- `overflow` output 1, sticky; set when a push is rejected.
- `underflow` output 1, sticky; set when a pop is rejected.
- `ram_write` output 1, RAM write strobe.
- `ram_read` output 1, RAM read strobe.
- `ram_wr_addr` output AW, RAM write address.
- `ram_rd_addr` output AW, RAM read address.
- `ram_data_in` output WIDTH, RAM write data.
- `ram_data_out` input WIDTH, RAM read data. The RAM registers this output one cycle after `ram_read`.

## Operation
**Pointers**
- `wptr` and `rptr` are AW+1 bits wide.
- `ram_wr_addr` = `wptr[AW-1:0]` and `ram_rd_addr` = `rptr[AW-1:0]`.
- The low bits wrap from DEPTH-1 to 0. The MSB toggles on each wrap.

**Flags**
- `empty` = (`wptr` == `rptr`).
- `full` = (low bits equal) and (MSBs differ).
- `count` = `wptr` - `rptr`, modulo 2^(AW+1).
- `full` and `empty` are derived from the registered pointers. There is no separate state register.

**Accept rules** (combinational from current inputs and flags)
- `push_ok` = `push` & !`full` & `rst`.
- `pop_ok` = `pop` & !`empty` & `rst`.
- A push while full is rejected even if a pop occurs in the same cycle. It sets `overflow`.
- A pop while empty is rejected even if a push occurs in the same cycle. It sets `underflow`.

**RAM drive**
- `ram_write` = `push_ok`, `ram_data_in` = `push_data`, `ram_read` = `pop_ok`.
- All are combinational and are 0 whenever `rst` = 0.

**Pointer and count update**
- On `push_ok`, `wptr` increments by 1.
- On `pop_ok`, `rptr` increments by 1.
- When both occur in one cycle, both pointers advance and `count` is unchanged.

**Read path**
- `pop_valid` is a register loaded with `pop_ok`.
- `pop_data` = `ram_data_out` (pass-through).
- A read-during-write to the same address cannot occur: `pop_ok` requires a non-empty FIFO, so `rptr` never equals `wptr` when a pop is accepted.

**Sticky flags**
- `overflow` and `underflow` are cleared only by reset.

## Timing
**Reset** (`rst` = 0 at a rising edge), next-cycle values:
- `wptr` = `rptr` = 0.
- `empty` = 1, `full` = 0, `count` = 0.
- `pop_valid` = 0, `overflow` = 0, `underflow` = 0.
- `ram_write` = `ram_read` = 0 combinationally while `rst` = 0.

**Reset mid-operation**
- Stored data is abandoned.
- A `pop_valid` that would have asserted on the following cycle is suppressed. The register is cleared on the same edge.

**Push**
- `push_ok` in cycle N writes the RAM at edge N.
- `count` and `empty` reflect the new entry from cycle N+1.
- Back-to-back pushes are sustained at 1 per cycle.

**Pop**
- `pop_ok` in cycle N gives `pop_valid` = 1 and `pop_data` = entry in cycle N+1. Latency is 1.
- Back-to-back pops are sustained at 1 per cycle.

**Flag timing**
- `full` asserts in the cycle after the 16th outstanding push.
- `empty` asserts in the cycle after the last pop.
- Data may still be in flight on `pop_data` in the cycle `empty` asserts.

**Wrap-around**
- After 16 push/pop pairs, addresses return to 0 with the pointer MSBs toggled.
- `empty` remains correct across the wrap.

## Test plan
- **Reset values:** drive `rst` = 0 for 2 cycles with `push` = `pop` = 1 -> `ram_write` = `ram_read` = 0, `empty` = 1, `count` = 0, `pop_valid` = 0 throughout; all flags clear after release.
- **Fill and drain:** push 0x10..0x1F on 16 consecutive cycles -> `full` = 1, `count` = 16; then 16 pops -> `pop_data` = 0x10..0x1F in order, each one cycle after its pop; finally `empty` = 1.
- **Overflow and underflow:** push 0xAA while full -> `ram_write` = 0, `overflow` = 1, `count` stays 16. Pop while empty -> `ram_read` = 0, `underflow` = 1, `pop_valid` stays 0.
- **Simultaneous push/pop:** at `count` = 5, assert `push` (0x55) and `pop` together for 20 cycles -> `count` stays 5 and the pointers wrap past 15. Then push and pop together when empty -> push accepted, pop rejected, `underflow` = 1, `count` = 1.
- **Wrap integrity:** 40 random (`$random` % 256) pushes interleaved with pops, `count` never exceeding 16 -> popped sequence equals pushed sequence; `ram_wr_addr`/`ram_rd_addr` follow 0..15 cyclically.
- **Reset mid-pop:** pop at `count` = 3 with `rst` = 0 in the same cycle -> `ram_read` = 0, no `pop_valid` next cycle, `count` = 0.
